// File: rtl/ctrl_pipe_stallable.sv
// rtl/ctrl_pipe_stallable.sv - stallable/flushable control pipeline with HI/LO mult/div occupancy tracker
module ctrl_pipe_stallable #(
  parameter int CW     = 17,
  parameter int NSTG   = 3,
  parameter int MULCYC = 4,
  parameter int DIVCYC = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CW-1:0]        ctrlD,
  input  logic                 validD,
  input  logic                 mdstartD,
  input  logic                 mddivD,
  input  logic                 mfhlD,
  input  logic [NSTG-1:0]      stall,
  input  logic [NSTG-1:0]      flush,
  output logic [NSTG*CW-1:0]   ctrl_out,
  output logic [NSTG-1:0]      valid_out,
  output logic                 stallD,
  output logic                 mdbusy,
  output logic                 mddone
);

  localparam int MAXCYC = (MULCYC > DIVCYC) ? MULCYC : DIVCYC;
  localparam int CNTW   = (MAXCYC > 1) ? $clog2(MAXCYC) : 1;

  typedef enum logic {IDLE, BUSY} mdState_t;

  mdState_t        state;
  logic [CNTW-1:0] count;
  logic [NSTG-1:0] es;
  logic            mdstallD;
  logic            mdStart;
  logic [CW-1:0]   stageCtrl  [NSTG];
  logic            stageValid [NSTG];

  assign mdbusy   = (state == BUSY);
  assign mddone   = mdbusy && (count == '0);
  assign mdstallD = validD & (mdstartD | mfhlD) & mdbusy;
  assign stallD   = es[0] | mdstallD;
  // Start coincides with the mult/div entering stage 0.
  assign mdStart  = validD & mdstartD & ~stallD & ~flush[0];

  for (genvar k = 0; k < NSTG; k++) begin : gStage
    // A hold anywhere downstream freezes this stage too.
    assign es[k] = |(stall >> k);
    assign ctrl_out[k*CW +: CW] = stageCtrl[k];
    assign valid_out[k]         = stageValid[k];

    if (k == 0) begin : gFirst
      always_ff @(posedge clk) begin
        if (reset || flush[0]) begin
          stageCtrl[0]  <= '0;
          stageValid[0] <= 1'b0;
        end else if (!es[0]) begin
          if (mdstallD) begin
            stageCtrl[0]  <= '0;
            stageValid[0] <= 1'b0;
          end else begin
            stageCtrl[0]  <= ctrlD;
            stageValid[0] <= validD;
          end
        end
      end
    end else begin : gNext
      always_ff @(posedge clk) begin
        if (reset || flush[k]) begin
          stageCtrl[k]  <= '0;
          stageValid[k] <= 1'b0;
        end else if (!es[k]) begin
          if (es[k-1]) begin
            stageCtrl[k]  <= '0;
            stageValid[k] <= 1'b0;
          end else begin
            stageCtrl[k]  <= stageCtrl[k-1];
            stageValid[k] <= stageValid[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdStart) begin
            state <= BUSY;
            count <= mddivD ? CNTW'(DIVCYC - 1) : CNTW'(MULCYC - 1);
          end
        end
        BUSY: begin
          if (count == '0) state <= IDLE;
          else             count <= count - CNTW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_stallable.sv
// tb/tb_ctrl_pipe_stallable.sv - vector table, mult/div corner sequences and randomized model check
module tb_ctrl_pipe_stallable;
  localparam int CW = 17, NSTG = 3, MULCYC = 4, DIVCYC = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [CW-1:0]       ctrlD;
  logic                validD, mdstartD, mddivD, mfhlD;
  logic [NSTG-1:0]     stall, flush;
  logic [NSTG*CW-1:0]  ctrl_out;
  logic [NSTG-1:0]     valid_out;
  logic                stallD, mdbusy, mddone;

  int checks = 0;
  int failures = 0;

  ctrl_pipe_stallable #(.CW(CW), .NSTG(NSTG), .MULCYC(MULCYC), .DIVCYC(DIVCYC)) dut (
    .clk(clk), .reset(reset), .ctrlD(ctrlD), .validD(validD), .mdstartD(mdstartD),
    .mddivD(mddivD), .mfhlD(mfhlD), .stall(stall), .flush(flush), .ctrl_out(ctrl_out),
    .valid_out(valid_out), .stallD(stallD), .mdbusy(mdbusy), .mddone(mddone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [2:0] st; logic [2:0] fl;
    logic vd; logic ms; logic dv; logic mf; logic [CW-1:0] cd;
    logic sd; logic [CW-1:0] e0; logic [CW-1:0] e1; logic [CW-1:0] e2;
    logic [2:0] ev; logic eb; logic ed;
  } vec_t;

  vec_t tbl [12];

  // Reference model: stage contents plus remaining busy cycles of HI/LO.
  logic [CW-1:0] mCtrl  [NSTG];
  logic          mValid [NSTG];
  int            mLeft;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] stg(input int k);
    return ctrl_out[k*CW +: CW];
  endfunction

  task automatic setIn(input logic r, input logic [NSTG-1:0] st, input logic [NSTG-1:0] fl,
                       input logic vd, input logic ms, input logic dv, input logic mf,
                       input logic [CW-1:0] cd);
    reset = r; stall = st; flush = fl; validD = vd;
    mdstartD = ms; mddivD = dv; mfhlD = mf; ctrlD = cd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    setIn(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  function automatic bit heldFrom(input int k);
    return (stall >> k) != 0;
  endfunction

  function automatic bit modelStallD();
    return heldFrom(0) || (validD && (mdstartD || mfhlD) && mLeft > 0);
  endfunction

  task automatic modelStep();
    bit mds, start;
    mds   = validD && (mdstartD || mfhlD) && mLeft > 0;
    start = validD && mdstartD && !modelStallD() && !flush[0];
    if (reset) begin
      for (int k = 0; k < NSTG; k++) begin mCtrl[k] = '0; mValid[k] = 1'b0; end
      mLeft = 0;
      return;
    end
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (flush[k]) begin
        mCtrl[k] = '0; mValid[k] = 1'b0;
      end else if (!heldFrom(k)) begin
        if (k > 0) begin
          if (heldFrom(k - 1)) begin mCtrl[k] = '0; mValid[k] = 1'b0; end
          else begin mCtrl[k] = mCtrl[k-1]; mValid[k] = mValid[k-1]; end
        end else if (mds) begin
          mCtrl[k] = '0; mValid[k] = 1'b0;
        end else begin
          mCtrl[k] = ctrlD; mValid[k] = validD;
        end
      end
    end
    if (mLeft > 0)  mLeft--;
    else if (start) mLeft = mddivD ? DIVCYC : MULCYC;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitCyc, run, doneAt;
    logic [2:0] ev;

    tbl[0]  = '{1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0};
    tbl[1]  = '{0, 3'b000, 3'b000, 1, 0, 0, 0, 1, 0, 1, 0, 0, 3'b001, 0, 0};
    tbl[2]  = '{0, 3'b000, 3'b000, 1, 0, 0, 0, 2, 0, 2, 1, 0, 3'b011, 0, 0};
    tbl[3]  = '{0, 3'b000, 3'b000, 1, 0, 0, 0, 3, 0, 3, 2, 1, 3'b111, 0, 0};
    tbl[4]  = '{0, 3'b000, 3'b000, 1, 0, 0, 0, 4, 0, 4, 3, 2, 3'b111, 0, 0};
    tbl[5]  = '{0, 3'b000, 3'b000, 1, 0, 0, 0, 5, 0, 5, 4, 3, 3'b111, 0, 0};
    tbl[6]  = '{0, 3'b010, 3'b000, 1, 0, 0, 0, 6, 1, 5, 4, 0, 3'b011, 0, 0};
    tbl[7]  = '{0, 3'b000, 3'b000, 1, 0, 0, 0, 6, 0, 6, 5, 4, 3'b111, 0, 0};
    tbl[8]  = '{0, 3'b001, 3'b001, 1, 0, 0, 0, 7, 1, 0, 0, 5, 3'b100, 0, 0};
    tbl[9]  = '{0, 3'b000, 3'b000, 1, 0, 0, 0, 7, 0, 7, 0, 0, 3'b001, 0, 0};
    tbl[10] = '{0, 3'b000, 3'b001, 1, 1, 0, 0, 8, 0, 0, 7, 0, 3'b010, 0, 0};
    tbl[11] = '{0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3'b100, 0, 0};

    for (int i = 0; i < 12; i++) begin
      setIn(tbl[i].rst, tbl[i].st, tbl[i].fl, tbl[i].vd, tbl[i].ms, tbl[i].dv, tbl[i].mf, tbl[i].cd);
      @(negedge clk);
      chk($sformatf("vec%0d.stallD", i), stallD, tbl[i].sd);
      tick();
      chk($sformatf("vec%0d.stage0", i), stg(0), tbl[i].e0);
      chk($sformatf("vec%0d.stage1", i), stg(1), tbl[i].e1);
      chk($sformatf("vec%0d.stage2", i), stg(2), tbl[i].e2);
      chk($sformatf("vec%0d.valid", i), valid_out, tbl[i].ev);
      chk($sformatf("vec%0d.mdbusy", i), mdbusy, tbl[i].eb);
      chk($sformatf("vec%0d.mddone", i), mddone, tbl[i].ed);
    end

    // mult followed by a waiting mfhi
    doReset();
    setIn(0, 0, 0, 1, 1, 0, 0, 'h11);
    tick();
    chk("mul.busyStart", mdbusy, 1);
    chk("mul.stage0", stg(0), 'h11);
    setIn(0, 0, 0, 1, 0, 0, 1, 'h22);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mul%0d.stallD", i), stallD, i < 4);
      chk($sformatf("mul%0d.mdbusy", i), mdbusy, i < 4);
      chk($sformatf("mul%0d.mddone", i), mddone, i == 3);
      tick();
      chk($sformatf("mul%0d.stage0", i), stg(0), (i < 4) ? 0 : 'h22);
      chk($sformatf("mul%0d.valid0", i), valid_out[0], i == 4);
    end

    // div immediately followed by another div
    doReset();
    setIn(0, 0, 0, 1, 1, 1, 0, 'h31);
    tick();
    setIn(0, 0, 0, 1, 1, 1, 0, 'h32);
    waitCyc = 0;
    while (waitCyc < 100) begin
      @(negedge clk);
      if (!stallD) break;
      waitCyc++;
      tick();
    end
    chk("div2.waitCycles", waitCyc, DIVCYC);
    chk("div2.gapBusy", mdbusy, 0);
    tick();
    chk("div2.stage0", stg(0), 'h32);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    run = 0; doneAt = -1;
    while (mdbusy && run < 100) begin
      if (mddone) doneAt = run;
      run++;
      tick();
    end
    chk("div2.busyCycles", run, DIVCYC);
    chk("div2.doneAt", doneAt, DIVCYC - 1);

    // reset in the middle of a div
    doReset();
    setIn(0, 0, 0, 1, 1, 1, 0, 'h41);
    tick();
    setIn(0, 0, 0, 1, 0, 0, 1, 'h42);
    for (int i = 0; i < 9; i++) tick();
    chk("rstdiv.busyBefore", mdbusy, 1);
    setIn(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(0, 0, 0, 1, 0, 0, 1, 'h44);
    chk("rstdiv.mdbusy", mdbusy, 0);
    chk("rstdiv.mddone", mddone, 0);
    chk("rstdiv.valid", valid_out, 0);
    @(negedge clk);
    chk("rstdiv.stallD", stallD, 0);
    tick();

    // randomized run against the model
    for (int k = 0; k < NSTG; k++) begin mCtrl[k] = '0; mValid[k] = 1'b0; end
    mLeft = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [NSTG-1:0] st, fl;
      for (int k = 0; k < NSTG; k++) begin
        st[k] = ($urandom_range(0, 9) == 0);
        fl[k] = ($urandom_range(0, 15) == 0);
      end
      setIn((i == 0) || ($urandom_range(0, 299) == 0), st, fl,
            $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, CW'($urandom));
      @(negedge clk);
      if (i > 0) chk($sformatf("rnd%0d.stallD", i), stallD, modelStallD());
      @(posedge clk);
      modelStep();
      #1;
      for (int k = 0; k < NSTG; k++) begin
        chk($sformatf("rnd%0d.stage%0d", i, k), stg(k), mCtrl[k]);
        ev[k] = mValid[k];
      end
      chk($sformatf("rnd%0d.valid", i), valid_out, ev);
      chk($sformatf("rnd%0d.mdbusy", i), mdbusy, mLeft > 0);
      chk($sformatf("rnd%0d.mddone", i), mddone, mLeft == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
